// File: rtl/mips_modport.sv
// Single-cycle MIPS32 subset core executing the instruction word on extInst each cycle.
// Optional bne support is enabled by defining MIPS_BNE_EN.
module mips_modport #(
   parameter int DM_WORDS = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] extInst,
   output logic [31:0] pc_current,
   output logic [31:0] pc_next,
   output logic [31:0] regf1,
   output logic [31:0] regf2,
   output logic [31:0] regmem_data,
   output logic [31:0] datamem_data
);

   localparam int AW = $clog2(DM_WORDS);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
`ifdef MIPS_BNE_EN
   localparam logic [5:0] OP_BNE   = 6'h05;
`endif

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   logic [31:0]        pc_q;
   logic [31:0]        rf [32];
   logic [31:0]        dm [DM_WORDS];

   logic [5:0]         op;
   logic [5:0]         funct;
   logic [4:0]         rs;
   logic [4:0]         rt;
   logic [4:0]         rd;
   logic [15:0]        imm;
   logic [25:0]        target;
   logic [4:0]         unused_shamt;

   logic signed [31:0] imm_sx;
   logic signed [31:0] rs_val;
   logic signed [31:0] rt_val;
   logic signed [31:0] alu;
   logic [31:0]        pc_plus4;
   logic [31:0]        br_target;
   logic [31:0]        dm_rd;
   logic [AW-1:0]      dm_idx;
   logic [4:0]         wr_reg;
   logic               reg_we;
   logic               mem_we;
   logic               is_lw;

   assign op           = extInst[31:26];
   assign rs           = extInst[25:21];
   assign rt           = extInst[20:16];
   assign rd           = extInst[15:11];
   assign unused_shamt = extInst[10:6];
   assign funct        = extInst[5:0];
   assign imm          = extInst[15:0];
   assign target       = extInst[25:0];

   assign imm_sx    = {{16{imm[15]}}, imm};
   assign rs_val    = (rs == 5'd0) ? 32'sd0 : rf[rs];
   assign rt_val    = (rt == 5'd0) ? 32'sd0 : rf[rt];
   assign pc_plus4  = pc_q + 32'd4;
   assign br_target = pc_plus4 + {imm_sx[29:0], 2'b00};

   // Unsupported encodings fall through with the add-immediate ALU result and no writes.
   always_comb begin
      alu     = rs_val + imm_sx;
      reg_we  = 1'b0;
      mem_we  = 1'b0;
      is_lw   = 1'b0;
      wr_reg  = rt;
      pc_next = pc_plus4;
      case (op)
         OP_RTYPE: begin
            wr_reg = rd;
            reg_we = 1'b1;
            case (funct)
               FN_ADD:  alu = rs_val + rt_val;
               FN_SUB:  alu = rs_val - rt_val;
               FN_AND:  alu = rs_val & rt_val;
               FN_OR:   alu = rs_val | rt_val;
               FN_SLT:  alu = (rs_val < rt_val) ? 32'sd1 : 32'sd0;
               default: reg_we = 1'b0;
            endcase
         end
         OP_ADDI: reg_we = 1'b1;
         OP_LW: begin
            reg_we = 1'b1;
            is_lw  = 1'b1;
         end
         OP_SW: mem_we = 1'b1;
         OP_BEQ: begin
            alu = rs_val - rt_val;
            if (rs_val == rt_val) pc_next = br_target;
         end
`ifdef MIPS_BNE_EN
         OP_BNE: begin
            alu = rs_val - rt_val;
            if (rs_val != rt_val) pc_next = br_target;
         end
`endif
         OP_J: pc_next = {pc_plus4[31:28], target, 2'b00};
         default: ;
      endcase
   end

   // Word index wraps: upper address bits and byte offset are dropped.
   assign dm_idx = alu[AW+1:2];
   assign dm_rd  = dm[dm_idx];

   assign pc_current   = pc_q;
   assign regf1        = rs_val;
   assign regf2        = rt_val;
   assign datamem_data = dm_rd;
   assign regmem_data  = is_lw ? dm_rd : alu;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q <= '0;
         for (int i = 0; i < 32; i++) rf[i] <= '0;
         for (int i = 0; i < DM_WORDS; i++) dm[i] <= '0;
      end else begin
         pc_q <= pc_next;
         if (reg_we && (wr_reg != 5'd0)) rf[wr_reg] <= regmem_data;
         if (mem_we) dm[dm_idx] <= rt_val;
      end
   end

endmodule

// File: tb/tb_mips_modport.sv
// Table-driven directed bench for mips_modport, plus hand sequences for
// mid-cycle reset, negative branch offset and bne (MIPS_BNE_EN aware).
module tb_mips_modport;

   logic        clk;
   logic        rst;
   logic [31:0] extInst;
   logic [31:0] pc_current;
   logic [31:0] pc_next;
   logic [31:0] regf1;
   logic [31:0] regf2;
   logic [31:0] regmem_data;
   logic [31:0] datamem_data;

   int errors = 0;
   int checks = 0;

   mips_modport #(.DM_WORDS(64)) dut (
      .clk          (clk),
      .rst          (rst),
      .extInst      (extInst),
      .pc_current   (pc_current),
      .pc_next      (pc_next),
      .regf1        (regf1),
      .regf2        (regf2),
      .regmem_data  (regmem_data),
      .datamem_data (datamem_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [31:0] pcn;
      logic [31:0] r1;
      logic [31:0] r2;
      logic [31:0] wb;
      logic [31:0] dm;
   } vec_t;

   localparam int NV = 23;
   vec_t tv [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // Wait to one time unit before the next rising edge.
   task automatic settle();
      @(negedge clk);
      #4;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      //             inst          pc            pc_next       regf1         regf2         regmem        datamem
      tv[0]  = '{32'h00000000, 32'h00000000, 32'h00000004, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};
      tv[1]  = '{32'h00000000, 32'h00000004, 32'h00000008, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};
      tv[2]  = '{32'h00000000, 32'h00000008, 32'h0000000C, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};
      tv[3]  = '{32'h20010005, 32'h0000000C, 32'h00000010, 32'h00000000, 32'h00000000, 32'h00000005, 32'h00000000};
      tv[4]  = '{32'h10210003, 32'h00000010, 32'h00000020, 32'h00000005, 32'h00000005, 32'h00000000, 32'h00000000};
      tv[5]  = '{32'h08000040, 32'h00000020, 32'h00000100, 32'h00000000, 32'h00000000, 32'h00000040, 32'h00000000};
      tv[6]  = '{32'h2002FFFD, 32'h00000100, 32'h00000104, 32'h00000000, 32'h00000000, 32'hFFFFFFFD, 32'h00000000};
      tv[7]  = '{32'h00221820, 32'h00000104, 32'h00000108, 32'h00000005, 32'hFFFFFFFD, 32'h00000002, 32'h00000000};
      tv[8]  = '{32'h00222022, 32'h00000108, 32'h0000010C, 32'h00000005, 32'hFFFFFFFD, 32'h00000008, 32'h00000000};
      tv[9]  = '{32'h0041282A, 32'h0000010C, 32'h00000110, 32'hFFFFFFFD, 32'h00000005, 32'h00000001, 32'h00000000};
      tv[10] = '{32'h00223824, 32'h00000110, 32'h00000114, 32'h00000005, 32'hFFFFFFFD, 32'h00000005, 32'h00000000};
      tv[11] = '{32'h00224025, 32'h00000114, 32'h00000118, 32'h00000005, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'h00000000};
      tv[12] = '{32'hAC010008, 32'h00000118, 32'h0000011C, 32'h00000000, 32'h00000005, 32'h00000008, 32'h00000000};
      tv[13] = '{32'h8C060008, 32'h0000011C, 32'h00000120, 32'h00000000, 32'h00000000, 32'h00000005, 32'h00000005};
      tv[14] = '{32'h00C04820, 32'h00000120, 32'h00000124, 32'h00000005, 32'h00000000, 32'h00000005, 32'h00000000};
      tv[15] = '{32'h8C0A0108, 32'h00000124, 32'h00000128, 32'h00000000, 32'h00000000, 32'h00000005, 32'h00000005};
      tv[16] = '{32'h10220003, 32'h00000128, 32'h0000012C, 32'h00000005, 32'hFFFFFFFD, 32'h00000008, 32'h00000005};
      tv[17] = '{32'h20000007, 32'h0000012C, 32'h00000130, 32'h00000000, 32'h00000000, 32'h00000007, 32'h00000000};
      tv[18] = '{32'h000A5820, 32'h00000130, 32'h00000134, 32'h00000000, 32'h00000005, 32'h00000005, 32'h00000000};
      tv[19] = '{32'hFC220004, 32'h00000134, 32'h00000138, 32'h00000005, 32'hFFFFFFFD, 32'h00000009, 32'h00000005};
      tv[20] = '{32'h0040103F, 32'h00000138, 32'h0000013C, 32'hFFFFFFFD, 32'h00000000, 32'h0000103C, 32'h00000000};
      tv[21] = '{32'h00406020, 32'h0000013C, 32'h00000140, 32'hFFFFFFFD, 32'h00000000, 32'hFFFFFFFD, 32'h00000000};
`ifdef MIPS_BNE_EN
      tv[22] = '{32'h14220002, 32'h00000140, 32'h0000014C, 32'h00000005, 32'hFFFFFFFD, 32'h00000008, 32'h00000005};
`else
      tv[22] = '{32'h14220002, 32'h00000140, 32'h00000144, 32'h00000005, 32'hFFFFFFFD, 32'h00000007, 32'h00000000};
`endif

      rst     = 1'b0;
      extInst = 32'h0;
      repeat (2) @(posedge clk);
      #3 rst = 1'b1;

      for (int i = 0; i < NV; i++) begin
         extInst = tv[i].inst;
         settle();
         chk($sformatf("v%0d pc_current", i),   pc_current,   tv[i].pc);
         chk($sformatf("v%0d pc_next", i),      pc_next,      tv[i].pcn);
         chk($sformatf("v%0d regf1", i),        regf1,        tv[i].r1);
         chk($sformatf("v%0d regf2", i),        regf2,        tv[i].r2);
         chk($sformatf("v%0d regmem_data", i),  regmem_data,  tv[i].wb);
         chk($sformatf("v%0d datamem_data", i), datamem_data, tv[i].dm);
         next_cycle();
      end

      // Mid-cycle reset: lw of word 2 reads 5 before, 0 after.
      extInst = 32'h8C0D0008;
      #1;
      chk("pre_rst datamem", datamem_data, 32'h5);
      chk("pre_rst regmem",  regmem_data,  32'h5);
      #1 rst = 1'b0;
      #1;
      chk("mid_rst pc_current", pc_current,   32'h0);
      chk("mid_rst pc_next",    pc_next,      32'h4);
      chk("mid_rst datamem",    datamem_data, 32'h0);
      chk("mid_rst regmem",     regmem_data,  32'h0);
      extInst = 32'h00220020;
      #1;
      chk("mid_rst regf1", regf1, 32'h0);
      chk("mid_rst regf2", regf2, 32'h0);
      next_cycle();
      chk("rst_hold pc_current", pc_current, 32'h0);
      #2 rst = 1'b1;

      extInst = 32'h20010005;
      settle();
      chk("post_rst pc_next", pc_next, 32'h4);
      chk("post_rst regf1",   regf1,   32'h0);
      next_cycle();

      extInst = 32'h08000008;
      settle();
      chk("j pc_current", pc_current, 32'h4);
      chk("j pc_next",    pc_next,    32'h20);
      next_cycle();

      extInst = 32'h1000FFFF;
      settle();
      chk("beq_neg pc_current", pc_current, 32'h20);
      chk("beq_neg pc_next",    pc_next,    32'h20);
      next_cycle();

      extInst = 32'h14200002;
      settle();
      chk("bne pc_current", pc_current, 32'h20);
      chk("bne regf1",      regf1,      32'h5);
`ifdef MIPS_BNE_EN
      chk("bne pc_next",    pc_next,    32'h2C);
`else
      chk("bne pc_next",    pc_next,    32'h24);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mips_modport.md
# mips_modport

Single-cycle MIPS32 integer core subset with an externally supplied instruction stream: each clock cycle it executes the 32-bit word presented on `extInst`. It has no instruction memory. It holds the PC, a 32x32 register file and a 64-word data memory. It exposes PC, register-read, write-back and memory-read values for a UVM driver/monitor pair that samples them through clocking blocks.

## Interface
Parameters:
- `DM_WORDS`, 64, data memory depth in 32-bit words (power of two).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `extInst`  in  32  instruction executed this cycle.
- `pc_current`  out  32  current PC register.
- `pc_next`  out  32  PC value loaded at the next rising edge (combinational).
- `regf1`  out  32  register file read port 1: `RF[rs]`, where rs = `extInst[25:21]`.
- `regf2`  out  32  register file read port 2: `RF[rt]`, where rt = `extInst[20:16]`.
- `regmem_data`  out  32  write-back mux output: memory read data for lw, otherwise ALU result.
- `datamem_data`  out  32  data memory read word at the ALU-result address.

## Operation
- **Supported instructions:**
  - R-type (op 0x00) with funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A; destination is rd.
  - addi 0x08, lw 0x23, sw 0x2B, beq 0x04, j 0x02.
- **Immediates:** 16-bit immediate is sign-extended for addi, lw, sw and beq.
- **Arithmetic:** add/sub/addi wrap modulo 2^32 with no overflow trap. slt is a signed compare giving 1 or 0.
- **Register writes:** R-type writes rd, addi/lw write rt. Writes to register 0 are discarded; `RF[0]` always reads 0.
- **Memory:** lw/sw address = rs + signext(imm). Word index = address bits [log2(DM_WORDS)+1:2]. Upper bits and low two bits are ignored, so addresses wrap. sw writes `RF[rt]`.
- **PC update:**
  - default: `pc_next` = pc+4.
  - beq with `RF[rs]`==`RF[rt]`: `pc_next` = pc+4 + (signext(imm)<<2).
  - j: `pc_next` = {pc+4[31:28], target26, 2'b00}.
- **Unsupported opcodes/functs:** behave as nop. No register or memory write; `pc_next` = pc+4. `regmem_data` = ALU result computed as add of rs and signext(imm).
- **Output values by instruction type:** for non-writing instructions, `regmem_data` still shows the ALU result. `datamem_data` always reflects the computed address, even for non-memory instructions. For beq the ALU performs subtract.

## Timing
- **Combinational outputs:** all outputs depend combinationally on state and `extInst`. They settle within the cycle in which `extInst` is applied; the environment drives 1 time unit after the edge and samples 1 time unit before the next edge.
- **Rising edge of `clk`:** the PC loads `pc_next`, the register write commits, and the memory write commits. Single-cycle latency; no stalls and no handshake.
- **Read-after-write:** a register or memory location written in cycle N is visible on the read outputs in cycle N+1. Within a cycle, reads return the old value.
- **Reset asserted (`rst`=0):** immediately sets PC=0, all registers = 0 and all data memory words = 0. While asserted, no writes occur and the PC is held at 0; outputs continue to reflect state and `extInst` combinationally.
- **Reset deasserted:** the first rising edge after release executes the current `extInst` at PC 0.
- **Reset mid-operation:** asserting reset part-way through a cycle aborts that cycle's writes.

## Configuration
- **`MIPS_BNE_EN`:**
  - Defined: opcode 0x05 (bne) is supported. It branches to pc+4 + (signext(imm)<<2) when `RF[rs]`!=`RF[rt]`, else goes to pc+4. No register or memory writes.
  - Undefined: opcode 0x05 is an unsupported opcode and behaves as a nop.

## Test plan
- **Reset:** apply reset, then release. Required: `pc_current`=0, `pc_next`=4, `regf1`=`regf2`=0. After 3 nop cycles, `pc_current`=0xC.
- **addi / add:** addi $1,$0,5 then addi $2,$0,-3 (0xFFFFFFFD), then add $3,$1,$2. Required on the add cycle: `regf1`=5, `regf2`=0xFFFFFFFD, `regmem_data`=2. Also sub $4,$1,$2 gives 8, and slt $5,$2,$1 gives 1.
- **Store/load:** sw $1,8($0) then lw $6,8($0). Required on the lw cycle: `datamem_data`=5, `regmem_data`=5. Next cycle, reading $6 gives 5. sw to address 0x108 aliases word 2.
- **beq:** beq $1,$1,+3 at PC 0x10 gives `pc_next`=0x20. beq $1,$2,+3 gives 0x14. Negative offset -1 at 0x20 gives 0x20.
- **Jump and register 0:** j 0x40 at PC 0x20 gives `pc_next`=0x100. addi $0,$0,7 leaves `regf1` reading $0 = 0 in the following cycle.
- **Reset mid-run and `MIPS_BNE_EN`:**
  - Asserting `rst` mid-cycle zeroes PC, registers and memory; a prior lw address then reads 0.
  - With `MIPS_BNE_EN`, bne $1,$2,+2 at 0 gives `pc_next`=0xC. Without it, `pc_next`=4.
